z2_bus_cycle: RTL and testbench
===============================

Name: z2_bus_cycle

Overview:
- Zorro II / 68000 slave bus-cycle sequencer for the board; sits directly upstream of the autoconfig and address-decode logic.
- Synchronises AS_n/UDS_n/LDS_n, produces the 2-bit z2_state consumed by autoconfig, RAM, IDE and control blocks, inserts per-target wait states, and drives DTACK and data-buffer controls back to the host bus.
- Autoconfig supplies its own one-cycle dtack; all other targets are acknowledged here.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of AS_n/UDS_n/LDS_n synchronisers (min 2).
- WAIT_RAM, 1, DATA-state cycles before ack for ram_access.
- WAIT_IO, 4, DATA-state cycles before ack for ide_access or ctrl_access.
- WAIT_FLASH, 6, DATA-state cycles before ack for flash_access.
- TIMEOUT, 255, DATA-state cycles with no ack before abandoning the cycle (8-bit counter).

Ports:
- CLK  in  1  board clock, at least 4x the 68000 bus clock.
- RESET_n  in  1  asynchronous active-low reset.
- AS_n  in  1  raw address strobe.
- UDS_n  in  1  raw upper data strobe.
- LDS_n  in  1  raw lower data strobe.
- RW  in  1  raw read/write (1 = read).
- autoconfig_cycle  in  1  decode: autoconfig space selected.
- ac_dtack  in  1  one-cycle ack from the autoconfig block.
- ram_access  in  1  decode: RAM selected.
- ide_access  in  1  decode: IDE selected.
- ctrl_access  in  1  decode: control registers selected.
- flash_access  in  1  decode: flash selected.
- z2_state  out  2  00 IDLE, 01 START, 10 DATA, 11 END.
- dtack_oe  out  1  1 = drive DTACK_n low.
- data_oe  out  1  1 = board drives the CPU data bus (read to a selected target).
- wr_strobe  out  1  one-cycle pulse: write data valid.
- target  out  3  latched target: 0 none, 1 autoconfig, 2 ide, 3 ctrl, 4 ram, 5 flash.
- timeout  out  1  one-cycle pulse when a cycle times out.

Behaviour:
- Reset (async): all sync FFs = 1 (strobes inactive); z2_state = IDLE; dtack_oe, data_oe, wr_strobe, timeout = 0; target = 0; wait counter = 0.
- as_s, ds_s are the synchronised AS_n and (UDS_n & LDS_n). RW and the decode inputs are sampled unsynchronised at the START→DATA transition; they are stable while AS is asserted.
- IDLE: if as_s == 0, go to START next cycle.
- START: if as_s == 1 (aborted cycle), go to IDLE.
  - Else if ds_s == 0, latch target by priority autoconfig > ide > ctrl > ram > flash.
    - target == 0: go to END with no dtack and no data_oe.
    - Otherwise: latch RW, clear counter, go to DATA.
    - Write: pulse wr_strobe for the first DATA cycle.
- DATA: counter increments each cycle and saturates at 255.
  - target 1: ack when ac_dtack == 1.
  - Others: ack when counter == the target's WAIT_x. WAIT_x = 0 acks on the first DATA cycle.
  - On ack: dtack_oe = 1 (registered, same edge as the transition), go to END.
  - If counter == TIMEOUT with no ack: pulse timeout, go to END, dtack_oe stays 0.
  - If as_s == 1 in DATA: go to IDLE, clear outputs; no dtack, no timeout.
  - Simultaneous ack and timeout: ack wins.
- data_oe = 1 in DATA and END while latched RW == 1 and target != 0; it drops with the IDLE transition.
- END: hold dtack_oe and data_oe until as_s == 1, then go to IDLE and clear dtack_oe, data_oe and target in the same edge.
- The minimum cycle returns to IDLE before the next AS falling edge. Back-to-back cycles need IDLE for at least 1 CLK.
- Reset mid-cycle: immediate IDLE, all outputs deasserted.

Test Plan:
- RAM read: AS_n low, 2 CLK later UDS/LDS low, RW = 1, ram_access = 1 → START, DATA; dtack_oe rises after 2 DATA cycles (WAIT_RAM = 1); data_oe = 1; after AS_n high, IDLE within SYNC_STAGES+1 CLK with dtack_oe = 0.
- Autoconfig write: autoconfig_cycle = 1, RW = 0, ac_dtack pulsed on the 3rd DATA cycle → wr_strobe is exactly 1 CLK on DATA entry; dtack_oe rises on the next edge; target = 1; data_oe stays 0 throughout.
- Unselected cycle: no decode high → START, END; dtack_oe and data_oe never assert; IDLE after AS_n rises.
- Priority: ide_access and ram_access both 1 → target = 2; ack after WAIT_IO = 4 (5 DATA cycles).
- Timeout with TIMEOUT = 8, autoconfig target and ac_dtack held 0 → timeout pulses once after 9 DATA cycles; END with no dtack.
- Abort and reset: AS_n deasserted in DATA → IDLE with no dtack. RESET_n low in END → dtack_oe = 0 and z2_state = 00 with no clock edge.

Source files
------------

// File: rtl/z2_bus_cycle.sv
// Zorro II / 68000 slave bus-cycle sequencer: strobe synchronisation, target latch,
// per-target wait states, DTACK and data-buffer control for the host bus.
module z2_bus_cycle #(
    parameter int SYNC_STAGES = 2,
    parameter int WAIT_RAM    = 1,
    parameter int WAIT_IO     = 4,
    parameter int WAIT_FLASH  = 6,
    parameter int TIMEOUT     = 255
) (
    input  logic       CLK,
    input  logic       RESET_n,
    input  logic       AS_n,
    input  logic       UDS_n,
    input  logic       LDS_n,
    input  logic       RW,
    input  logic       autoconfig_cycle,
    input  logic       ac_dtack,
    input  logic       ram_access,
    input  logic       ide_access,
    input  logic       ctrl_access,
    input  logic       flash_access,
    output logic [1:0] z2_state,
    output logic       dtack_oe,
    output logic       data_oe,
    output logic       wr_strobe,
    output logic [2:0] target,
    output logic       timeout
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_START = 2'b01,
        S_DATA  = 2'b10,
        S_END   = 2'b11
    } state_t;

    localparam logic [2:0] TGT_NONE  = 3'd0;
    localparam logic [2:0] TGT_AC    = 3'd1;
    localparam logic [2:0] TGT_IDE   = 3'd2;
    localparam logic [2:0] TGT_CTRL  = 3'd3;
    localparam logic [2:0] TGT_RAM   = 3'd4;
    localparam logic [2:0] TGT_FLASH = 3'd5;

    localparam logic [7:0] W_RAM   = WAIT_RAM[7:0];
    localparam logic [7:0] W_IO    = WAIT_IO[7:0];
    localparam logic [7:0] W_FLASH = WAIT_FLASH[7:0];
    localparam logic [7:0] W_TOUT  = TIMEOUT[7:0];

    state_t                 state;
    logic [SYNC_STAGES-1:0] as_sync;
    logic [SYNC_STAGES-1:0] uds_sync;
    logic [SYNC_STAGES-1:0] lds_sync;
    logic                   as_s;
    logic                   ds_s;
    logic [7:0]             wait_cnt;
    logic [7:0]             wait_limit;
    logic [2:0]             decode_target;
    logic                   ack;

    // Strobes are synchronised individually; ds_s is low when either byte strobe is low.
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            as_sync  <= '1;
            uds_sync <= '1;
            lds_sync <= '1;
        end else begin
            as_sync  <= {as_sync[SYNC_STAGES-2:0], AS_n};
            uds_sync <= {uds_sync[SYNC_STAGES-2:0], UDS_n};
            lds_sync <= {lds_sync[SYNC_STAGES-2:0], LDS_n};
        end
    end

    assign as_s = as_sync[SYNC_STAGES-1];
    assign ds_s = uds_sync[SYNC_STAGES-1] & lds_sync[SYNC_STAGES-1];

    always_comb begin
        decode_target = TGT_NONE;
        if (autoconfig_cycle)  decode_target = TGT_AC;
        else if (ide_access)   decode_target = TGT_IDE;
        else if (ctrl_access)  decode_target = TGT_CTRL;
        else if (ram_access)   decode_target = TGT_RAM;
        else if (flash_access) decode_target = TGT_FLASH;
    end

    always_comb begin
        wait_limit = 8'd0;
        case (target)
            TGT_IDE, TGT_CTRL: wait_limit = W_IO;
            TGT_RAM:           wait_limit = W_RAM;
            TGT_FLASH:         wait_limit = W_FLASH;
            default:           wait_limit = 8'd0;
        endcase
    end

    // Autoconfig acknowledges itself; everything else is a fixed wait count.
    assign ack = (target == TGT_AC) ? ac_dtack : (wait_cnt == wait_limit);

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state     <= S_IDLE;
            dtack_oe  <= 1'b0;
            data_oe   <= 1'b0;
            wr_strobe <= 1'b0;
            timeout   <= 1'b0;
            target    <= TGT_NONE;
            wait_cnt  <= 8'd0;
        end else begin
            wr_strobe <= 1'b0;
            timeout   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!as_s) state <= S_START;
                end
                S_START: begin
                    if (as_s) begin
                        state <= S_IDLE;
                    end else if (!ds_s) begin
                        target   <= decode_target;
                        wait_cnt <= 8'd0;
                        if (decode_target == TGT_NONE) begin
                            state <= S_END;
                        end else begin
                            state     <= S_DATA;
                            data_oe   <= RW;
                            wr_strobe <= ~RW;
                        end
                    end
                end
                S_DATA: begin
                    if (wait_cnt != 8'hFF) wait_cnt <= wait_cnt + 8'd1;
                    // Abort beats ack, and ack beats timeout.
                    if (as_s) begin
                        state    <= S_IDLE;
                        dtack_oe <= 1'b0;
                        data_oe  <= 1'b0;
                        target   <= TGT_NONE;
                    end else if (ack) begin
                        state    <= S_END;
                        dtack_oe <= 1'b1;
                    end else if (wait_cnt == W_TOUT) begin
                        state   <= S_END;
                        timeout <= 1'b1;
                    end
                end
                S_END: begin
                    if (as_s) begin
                        state    <= S_IDLE;
                        dtack_oe <= 1'b0;
                        data_oe  <= 1'b0;
                        target   <= TGT_NONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign z2_state = state;

endmodule

// File: tb/tb_z2_bus_cycle.sv
// Directed bench for z2_bus_cycle; DUT built with TIMEOUT = 8 so the timeout path is short.
module tb_z2_bus_cycle;

    logic       CLK = 1'b0;
    logic       RESET_n;
    logic       AS_n, UDS_n, LDS_n, RW;
    logic       autoconfig_cycle, ac_dtack, ram_access, ide_access, ctrl_access, flash_access;
    logic [1:0] z2_state;
    logic       dtack_oe, data_oe, wr_strobe, timeout;
    logic [2:0] target;

    int checks = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    z2_bus_cycle #(
        .SYNC_STAGES(2), .WAIT_RAM(1), .WAIT_IO(4), .WAIT_FLASH(6), .TIMEOUT(8)
    ) dut (
        .CLK(CLK), .RESET_n(RESET_n), .AS_n(AS_n), .UDS_n(UDS_n), .LDS_n(LDS_n), .RW(RW),
        .autoconfig_cycle(autoconfig_cycle), .ac_dtack(ac_dtack), .ram_access(ram_access),
        .ide_access(ide_access), .ctrl_access(ctrl_access), .flash_access(flash_access),
        .z2_state(z2_state), .dtack_oe(dtack_oe), .data_oe(data_oe), .wr_strobe(wr_strobe),
        .target(target), .timeout(timeout)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic drive_idle();
        AS_n = 1'b1; UDS_n = 1'b1; LDS_n = 1'b1; RW = 1'b1; ac_dtack = 1'b0;
        {autoconfig_cycle, ide_access, ctrl_access, ram_access, flash_access} = 5'b0;
    endtask

    // AS and both data strobes fall together: START after 3 edges, DATA after 4.
    task automatic start_cycle(input logic [4:0] dec, input logic rw);
        {autoconfig_cycle, ide_access, ctrl_access, ram_access, flash_access} = dec;
        RW = rw; AS_n = 1'b0; UDS_n = 1'b0; LDS_n = 1'b0;
    endtask

    task automatic test_reset();
        drive_idle();
        RESET_n = 1'b0;
        #12;
        checks++; if (z2_state !== 2'b00) begin failures++; $display("FAIL reset_state got=%b exp=00", z2_state); end
        checks++; if ({dtack_oe, data_oe, wr_strobe, timeout} !== 4'b0) begin failures++; $display("FAIL reset_outs got=%b exp=0000", {dtack_oe, data_oe, wr_strobe, timeout}); end
        checks++; if (target !== 3'd0) begin failures++; $display("FAIL reset_target got=%0d exp=0", target); end
        @(negedge CLK);
        RESET_n = 1'b1;
        tick(3);
        checks++; if (z2_state !== 2'b00) begin failures++; $display("FAIL idle_after_reset got=%b exp=00", z2_state); end
    endtask

    task automatic test_ram_read();
        ram_access = 1'b1; RW = 1'b1; AS_n = 1'b0;
        tick(2);
        checks++; if (z2_state !== 2'b00) begin failures++; $display("FAIL ram_sync_delay got=%b exp=00", z2_state); end
        UDS_n = 1'b0; LDS_n = 1'b0;
        tick(1);
        checks++; if (z2_state !== 2'b01) begin failures++; $display("FAIL ram_start got=%b exp=01", z2_state); end
        tick(1);
        checks++; if (z2_state !== 2'b01) begin failures++; $display("FAIL ram_start_hold got=%b exp=01", z2_state); end
        tick(1);
        checks++; if ({z2_state, dtack_oe, data_oe, target} !== {2'b10, 1'b0, 1'b1, 3'd4}) begin failures++; $display("FAIL ram_data_entry got=%b/%b/%b/%0d exp=10/0/1/4", z2_state, dtack_oe, data_oe, target); end
        tick(1);
        checks++; if ({z2_state, dtack_oe} !== 3'b100) begin failures++; $display("FAIL ram_data2 got=%b/%b exp=10/0", z2_state, dtack_oe); end
        tick(1);
        checks++; if ({z2_state, dtack_oe, data_oe} !== 4'b1111) begin failures++; $display("FAIL ram_ack got=%b/%b/%b exp=11/1/1", z2_state, dtack_oe, data_oe); end
        tick(1);
        AS_n = 1'b1; UDS_n = 1'b1; LDS_n = 1'b1;
        tick(2);
        checks++; if ({z2_state, dtack_oe} !== 3'b111) begin failures++; $display("FAIL ram_end_hold got=%b/%b exp=11/1", z2_state, dtack_oe); end
        tick(1);
        checks++; if ({z2_state, dtack_oe, data_oe, target} !== {2'b00, 1'b0, 1'b0, 3'd0}) begin failures++; $display("FAIL ram_release got=%b/%b/%b/%0d exp=00/0/0/0", z2_state, dtack_oe, data_oe, target); end
        drive_idle();
        tick(1);
    endtask

    task automatic test_ac_write();
        start_cycle(5'b10000, 1'b0);
        tick(4);
        checks++; if ({z2_state, wr_strobe, data_oe, target} !== {2'b10, 1'b1, 1'b0, 3'd1}) begin failures++; $display("FAIL ac_entry got=%b/%b/%b/%0d exp=10/1/0/1", z2_state, wr_strobe, data_oe, target); end
        tick(1);
        checks++; if ({wr_strobe, dtack_oe, data_oe} !== 3'b000) begin failures++; $display("FAIL ac_strobe_width got=%b exp=000", {wr_strobe, dtack_oe, data_oe}); end
        tick(1);
        checks++; if ({z2_state, dtack_oe} !== 3'b100) begin failures++; $display("FAIL ac_wait got=%b/%b exp=10/0", z2_state, dtack_oe); end
        ac_dtack = 1'b1;
        tick(1);
        ac_dtack = 1'b0;
        checks++; if ({z2_state, dtack_oe, data_oe, target} !== {2'b11, 1'b1, 1'b0, 3'd1}) begin failures++; $display("FAIL ac_ack got=%b/%b/%b/%0d exp=11/1/0/1", z2_state, dtack_oe, data_oe, target); end
        AS_n = 1'b1; UDS_n = 1'b1; LDS_n = 1'b1;
        tick(3);
        checks++; if ({z2_state, dtack_oe, data_oe} !== 4'b0000) begin failures++; $display("FAIL ac_release got=%b/%b/%b exp=00/0/0", z2_state, dtack_oe, data_oe); end
        drive_idle();
        tick(1);
    endtask

    task automatic test_unselected();
        start_cycle(5'b00000, 1'b1);
        tick(3);
        checks++; if (z2_state !== 2'b01) begin failures++; $display("FAIL unsel_start got=%b exp=01", z2_state); end
        tick(1);
        checks++; if ({z2_state, dtack_oe, data_oe, target} !== {2'b11, 1'b0, 1'b0, 3'd0}) begin failures++; $display("FAIL unsel_end got=%b/%b/%b/%0d exp=11/0/0/0", z2_state, dtack_oe, data_oe, target); end
        tick(2);
        checks++; if ({z2_state, dtack_oe, data_oe} !== 4'b1100) begin failures++; $display("FAIL unsel_hold got=%b/%b/%b exp=11/0/0", z2_state, dtack_oe, data_oe); end
        AS_n = 1'b1; UDS_n = 1'b1; LDS_n = 1'b1;
        tick(3);
        checks++; if (z2_state !== 2'b00) begin failures++; $display("FAIL unsel_release got=%b exp=00", z2_state); end
        drive_idle();
        tick(1);
    endtask

    // Decode order {autoconfig, ide, ctrl, ram, flash}; ack comes after data_cycles DATA cycles.
    task automatic test_wait(input string name, input logic [4:0] dec, input logic rw,
                             input logic [2:0] exp_tgt, input int data_cycles);
        start_cycle(dec, rw);
        tick(4);
        checks++; if ({z2_state, target, wr_strobe} !== {2'b10, exp_tgt, ~rw}) begin failures++; $display("FAIL %s_entry got=%b/%0d/%b exp=10/%0d/%b", name, z2_state, target, wr_strobe, exp_tgt, ~rw); end
        tick(data_cycles - 1);
        checks++; if ({z2_state, dtack_oe} !== 3'b100) begin failures++; $display("FAIL %s_wait got=%b/%b exp=10/0", name, z2_state, dtack_oe); end
        tick(1);
        checks++; if ({z2_state, dtack_oe, data_oe} !== {2'b11, 1'b1, rw}) begin failures++; $display("FAIL %s_ack got=%b/%b/%b exp=11/1/%b", name, z2_state, dtack_oe, data_oe, rw); end
        AS_n = 1'b1; UDS_n = 1'b1; LDS_n = 1'b1;
        tick(3);
        checks++; if ({z2_state, dtack_oe, target} !== {2'b00, 1'b0, 3'd0}) begin failures++; $display("FAIL %s_release got=%b/%b/%0d exp=00/0/0", name, z2_state, dtack_oe, target); end
        drive_idle();
        tick(1);
    endtask

    task automatic test_timeout();
        start_cycle(5'b10000, 1'b1);
        tick(4);
        checks++; if ({z2_state, data_oe} !== 3'b101) begin failures++; $display("FAIL tout_entry got=%b/%b exp=10/1", z2_state, data_oe); end
        tick(8);
        checks++; if ({z2_state, timeout} !== 3'b100) begin failures++; $display("FAIL tout_early got=%b/%b exp=10/0", z2_state, timeout); end
        tick(1);
        checks++; if ({z2_state, timeout, dtack_oe} !== 4'b1110) begin failures++; $display("FAIL tout_pulse got=%b/%b/%b exp=11/1/0", z2_state, timeout, dtack_oe); end
        tick(1);
        checks++; if ({z2_state, timeout, dtack_oe} !== 4'b1100) begin failures++; $display("FAIL tout_once got=%b/%b/%b exp=11/0/0", z2_state, timeout, dtack_oe); end
        AS_n = 1'b1; UDS_n = 1'b1; LDS_n = 1'b1;
        tick(3);
        checks++; if ({z2_state, data_oe} !== 3'b000) begin failures++; $display("FAIL tout_release got=%b/%b exp=00/0", z2_state, data_oe); end
        drive_idle();
        tick(1);
    endtask

    task automatic test_abort();
        start_cycle(5'b00001, 1'b1);
        tick(5);
        AS_n = 1'b1; UDS_n = 1'b1; LDS_n = 1'b1;
        tick(2);
        checks++; if ({z2_state, dtack_oe} !== 3'b100) begin failures++; $display("FAIL abort_pending got=%b/%b exp=10/0", z2_state, dtack_oe); end
        tick(1);
        checks++; if ({z2_state, dtack_oe, data_oe, timeout, target} !== {2'b00, 3'b000, 3'd0}) begin failures++; $display("FAIL abort_idle got=%b/%b/%b/%b/%0d exp=00/0/0/0/0", z2_state, dtack_oe, data_oe, timeout, target); end
        tick(4);
        checks++; if ({z2_state, dtack_oe, timeout} !== 4'b0000) begin failures++; $display("FAIL abort_quiet got=%b/%b/%b exp=00/0/0", z2_state, dtack_oe, timeout); end
        drive_idle();
    endtask

    task automatic test_reset_mid();
        start_cycle(5'b00010, 1'b1);
        tick(6);
        checks++; if ({z2_state, dtack_oe} !== 3'b111) begin failures++; $display("FAIL rst_pre got=%b/%b exp=11/1", z2_state, dtack_oe); end
        #2 RESET_n = 1'b0;
        #1;
        checks++; if ({z2_state, dtack_oe, data_oe, target} !== {2'b00, 1'b0, 1'b0, 3'd0}) begin failures++; $display("FAIL rst_async got=%b/%b/%b/%0d exp=00/0/0/0", z2_state, dtack_oe, data_oe, target); end
        drive_idle();
        #1 RESET_n = 1'b1;
        tick(2);
        checks++; if ({z2_state, dtack_oe} !== 3'b000) begin failures++; $display("FAIL rst_recover got=%b/%b exp=00/0", z2_state, dtack_oe); end
    endtask

    task automatic test_back_to_back();
        start_cycle(5'b00010, 1'b0);
        tick(6);
        AS_n = 1'b1; UDS_n = 1'b1; LDS_n = 1'b1;
        tick(3);
        checks++; if (z2_state !== 2'b00) begin failures++; $display("FAIL b2b_gap got=%b exp=00", z2_state); end
        start_cycle(5'b00010, 1'b1);
        tick(4);
        checks++; if ({z2_state, data_oe, wr_strobe} !== 4'b1010) begin failures++; $display("FAIL b2b_second got=%b/%b/%b exp=10/1/0", z2_state, data_oe, wr_strobe); end
        tick(2);
        checks++; if ({z2_state, dtack_oe} !== 3'b111) begin failures++; $display("FAIL b2b_ack got=%b/%b exp=11/1", z2_state, dtack_oe); end
        AS_n = 1'b1; UDS_n = 1'b1; LDS_n = 1'b1;
        tick(3);
        drive_idle();
    endtask

    initial begin
        test_reset();
        test_ram_read();
        test_ac_write();
        test_unselected();
        test_wait("prio_ide", 5'b01010, 1'b1, 3'd2, 5);
        test_wait("prio_ctrl", 5'b00110, 1'b0, 3'd3, 5);
        test_wait("prio_ram", 5'b00011, 1'b1, 3'd4, 2);
        test_wait("flash", 5'b00001, 1'b0, 3'd5, 7);
        test_timeout();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
